down_timer: RTL and testbench
=============================

Name: down_timer

Overview:
- Loadable, programmable down-counter/timer. Complements the free-running 8-bit up counter.
- Software or an upstream FSM loads a count value and starts it. The block decrements on enabled cycles and flags terminal count with a one-cycle pulse.
- Supports pause/resume, abort, and optional auto-reload for periodic tick generation.
- Sits beside the up counter in the timing/control path of the digital core.

Parameters:
WIDTH, 8, bit width of count, load_value and internal reload register
PRESCALE, 4, enabled cycles per decrement; only used when DOWN_TIMER_PRESCALE_EN is defined; legal range >= 2

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset; 0 clears all state immediately
enable  input  1  count qualifier; decrement only on cycles with enable=1 while RUN
load  input  1  capture load_value into count and reload register
load_value  input  WIDTH  value captured on load
start  input  1  begin or resume counting
stop  input  1  pause (from RUN) or abort (from PAUSE)
auto_reload  input  1  at terminal count, reload and keep running instead of stopping
count  output  WIDTH  current counter value, registered
busy  output  1  high in RUN or PAUSE
done  output  1  one-cycle registered pulse at terminal count

Behaviour:
- Reset (reset=0, async):
  - count=0, reload_reg=0, state=IDLE, busy=0, done=0.
  - Release is synchronous to clk; the first active edge after release evaluates inputs normally.
- States: IDLE, RUN, PAUSE, DONE (2-bit encoding). busy = (state==RUN || state==PAUSE), registered/decoded with no combinational path from inputs.
- Priority per cycle: load > stop > start > decrement.
- load (any state):
  - count<=load_value, reload_reg<=load_value.
  - IDLE/RUN/PAUSE: state unchanged. DONE: state goes to IDLE.
  - Load overrides a decrement in the same cycle, and done is not pulsed that cycle.
  - load+start in the same cycle in IDLE or DONE: go to RUN if load_value!=0, else IDLE.
- start:
  - IDLE: go to RUN if count!=0; ignored if count==0.
  - PAUSE: go to RUN, count unchanged.
  - DONE: count<=reload_reg; go to RUN if reload_reg!=0, else IDLE.
  - RUN: no effect.
- stop:
  - RUN: go to PAUSE, count held.
  - PAUSE: go to IDLE, count held (abort).
  - IDLE/DONE: no effect.
  - start+stop in the same cycle: stop wins.
- Decrement (RUN, enable=1, no load/stop):
  - count>1: count<=count-1.
  - count==1, auto_reload=1, reload_reg!=0: count<=reload_reg, stay RUN, done<=1. Period is exactly reload_reg enabled cycles.
  - count==1 otherwise: count<=0, go to DONE, done<=1.
- enable=0 in RUN: count held, no done.
- done is high for exactly one cycle, coincident with the first cycle count shows its terminal/reload value. Default 0.
- No wrap-around: count never decrements below 0 and never wraps to all-ones.
- Changing auto_reload mid-run takes effect at the next terminal count.

Optional Feature:
DOWN_TIMER_PRESCALE_EN
- Defined:
  - Internal prescale counter, width ceil(log2(PRESCALE)).
  - In RUN, it increments on each enable=1 cycle. A decrement happens only when it reaches PRESCALE-1, then it wraps to 0.
  - Cleared to 0 on reset, load, start, stop, and on entry to DONE.
  - Terminal count therefore occurs after count*PRESCALE enabled cycles.
- Undefined: no prescale logic; decrement on every enabled RUN cycle. PRESCALE is ignored.

Test Plan:
1. reset=0 mid-count (count=0x37, RUN) -> count=0, busy=0, done=0 immediately, without waiting for a clk edge; outputs stay cleared until the first edge after release.
2. load_value=5, load, then start, enable=1 continuously -> count 5,4,3,2,1,0 on successive edges; done=1 only on the cycle count=0; busy falls the same edge; state DONE.
3. load_value=3, auto_reload=1, start, enable=1 for 10 cycles -> count 3,2,1,3,2,1,3,...; done pulses every 3rd cycle; busy stays 1; count never shows 0.
4. load 10, start, 3 decrements (count=7), stop -> count holds 7 for 5 cycles; start -> resumes 6; stop twice -> IDLE, busy=0, count 6. Same-cycle start+stop in PAUSE -> goes to IDLE.
5. load_value=0, load+start -> stays IDLE, busy=0, no done. In RUN with count=4, load 9 and enable=1 in the same cycle -> count=9, no decrement, state RUN.
6. With DOWN_TIMER_PRESCALE_EN, PRESCALE=4: load 2, start, enable=1 -> count 2 for 4 cycles, 1 for 4 cycles, then 0 with done; total 8 enabled cycles.

Source files
------------

// File: rtl/down_timer.sv
// -----------------------------------------------------------------------------
// down_timer
//
// Loadable, programmable down-counter/timer for the timing/control path.
// A value is loaded, counting is started, and the counter decrements on
// enabled cycles while running. Reaching terminal count raises a one-cycle
// done pulse. Counting can be paused and resumed, or aborted. With
// auto-reload set, the timer reloads at terminal count and keeps running,
// which produces a periodic tick.
//
// Optional build macro:
//   DOWN_TIMER_PRESCALE_EN - when defined, each decrement needs PRESCALE
//                            enabled RUN cycles instead of one.
//
// Ports:
//   clk_i          system clock, rising edge
//   rst_ni         asynchronous active-low reset
//   enable_i       count qualifier while running
//   load_i         capture load_value_i into count and the reload register
//   load_value_i   value captured on load
//   start_i        begin or resume counting
//   stop_i         pause (from RUN) or abort (from PAUSE)
//   auto_reload_i  reload and keep running at terminal count
//   count_o        current counter value (registered)
//   busy_o         high in RUN or PAUSE (decoded from state register)
//   done_o         one-cycle registered pulse at terminal count
// -----------------------------------------------------------------------------
module down_timer #(
   parameter int WIDTH    = 8,
   parameter int PRESCALE = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             enable_i,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_value_i,
   input  logic             start_i,
   input  logic             stop_i,
   input  logic             auto_reload_i,
   output logic [WIDTH-1:0] count_o,
   output logic             busy_o,
   output logic             done_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } state_e;

   localparam logic [WIDTH-1:0] CountOne = WIDTH'(1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] reload_q, reload_d;
   logic             done_q, done_d;
   logic             tick;

`ifdef DOWN_TIMER_PRESCALE_EN
   localparam int            PresW   = $clog2(PRESCALE);
   localparam logic [PresW-1:0] PresMax = PresW'(PRESCALE - 1);

   logic [PresW-1:0] presc_q, presc_d;
`endif

   // State, count, reload value and done pulse all live in one register bank
   // so that every output is a flop or a pure decode of the state flop.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         count_q  <= '0;
         reload_q <= '0;
         done_q   <= 1'b0;
`ifdef DOWN_TIMER_PRESCALE_EN
         presc_q  <= '0;
`endif
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         reload_q <= reload_d;
         done_q   <= done_d;
`ifdef DOWN_TIMER_PRESCALE_EN
         presc_q  <= presc_d;
`endif
      end
   end

   // Next-state logic. Controls are prioritised load > stop > start >
   // decrement, so at most one of the branches below acts in a cycle.
   // A start while already running has no effect and lets the decrement
   // proceed normally.
   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      reload_d = reload_q;
      done_d   = 1'b0;
      tick     = 1'b0;
`ifdef DOWN_TIMER_PRESCALE_EN
      presc_d  = presc_q;
`endif

      if (load_i) begin
         count_d  = load_value_i;
         reload_d = load_value_i;
         if (start_i && (state_q == IDLE || state_q == DONE)) begin
            state_d = (load_value_i != '0) ? RUN : IDLE;
         end else if (state_q == DONE) begin
            state_d = IDLE;
         end
`ifdef DOWN_TIMER_PRESCALE_EN
         presc_d = '0;
`endif
      end else if (stop_i) begin
         if (state_q == RUN) begin
            state_d = PAUSE;
         end else if (state_q == PAUSE) begin
            state_d = IDLE;
         end
`ifdef DOWN_TIMER_PRESCALE_EN
         presc_d = '0;
`endif
      end else if (start_i && state_q != RUN) begin
         case (state_q)
            IDLE:    if (count_q != '0) state_d = RUN;
            PAUSE:   state_d = RUN;
            DONE: begin
               count_d = reload_q;
               state_d = (reload_q != '0) ? RUN : IDLE;
            end
            default: state_d = state_q;
         endcase
`ifdef DOWN_TIMER_PRESCALE_EN
         presc_d = '0;
`endif
      end else if (state_q == RUN && enable_i) begin
`ifdef DOWN_TIMER_PRESCALE_EN
         if (presc_q == PresMax) begin
            presc_d = '0;
            tick    = 1'b1;
         end else begin
            presc_d = presc_q + PresW'(1);
         end
`else
         tick = 1'b1;
`endif
         // Terminal count is detected at 1 rather than 0 so that done lines
         // up with the first cycle the terminal or reload value is visible,
         // and a reload period equals the reload value exactly.
         if (tick) begin
            if (count_q > CountOne) begin
               count_d = count_q - CountOne;
            end else if (count_q == CountOne) begin
               done_d = 1'b1;
               if (auto_reload_i && reload_q != '0) begin
                  count_d = reload_q;
               end else begin
                  count_d = '0;
                  state_d = DONE;
               end
            end
         end
      end
   end

   assign count_o = count_q;
   assign busy_o  = (state_q == RUN) || (state_q == PAUSE);
   assign done_o  = done_q;

endmodule

// File: tb/tb_down_timer.sv
// -----------------------------------------------------------------------------
// tb_down_timer
//
// Directed testbench for down_timer. Inputs are driven on the falling edge
// and outputs are sampled on the following falling edge, so every sample
// sits half a cycle away from the active rising edge.
// -----------------------------------------------------------------------------
module tb_down_timer;

   localparam int WIDTH = 8;

   logic             clk;
   logic             rstN;
   logic             enable;
   logic             load;
   logic [WIDTH-1:0] loadValue;
   logic             start;
   logic             stop;
   logic             autoReload;
   logic [WIDTH-1:0] count;
   logic             busy;
   logic             done;

   int checks;
   int errors;

   down_timer #(
      .WIDTH    (WIDTH),
      .PRESCALE (4)
   ) dut (
      .clk_i         (clk),
      .rst_ni        (rstN),
      .enable_i      (enable),
      .load_i        (load),
      .load_value_i  (loadValue),
      .start_i       (start),
      .stop_i        (stop),
      .auto_reload_i (autoReload),
      .count_o       (count),
      .busy_o        (busy),
      .done_o        (done)
   );

   // 10 ns clock period
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Drive all control inputs in one go
   task automatic applyStimulus(input logic ld, input logic [WIDTH-1:0] lv,
                                input logic st, input logic sp,
                                input logic en, input logic ar);
      load       = ld;
      loadValue  = lv;
      start      = st;
      stop       = sp;
      enable     = en;
      autoReload = ar;
   endtask

   // Advance one rising edge and return on the next falling edge
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Check the three outputs together
   task automatic checkAll(input string tag, input int c, input int b, input int d);
      checkOutput({tag, ".count"}, int'(count), c);
      checkOutput({tag, ".busy"},  int'(busy),  b);
      checkOutput({tag, ".done"},  int'(done),  d);
   endtask

   int expSeq[10] = '{2, 1, 3, 2, 1, 3, 2, 1, 3, 2};

   initial begin
      checks = 0;
      errors = 0;
      rstN   = 1'b0;
      applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (2) @(negedge clk);
      checkAll("reset", 0, 0, 0);
      rstN = 1'b1;
      @(negedge clk);

      // Asynchronous reset in the middle of a count
      applyStimulus(1'b1, 8'h37, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      checkAll("r.load", 'h37, 1, 0);
      applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      checkAll("r.dec", 'h36, 1, 0);
      #2 rstN = 1'b0;
      #1 checkAll("r.async", 0, 0, 0);
      tick();
      checkAll("r.held", 0, 0, 0);
      rstN = 1'b1;
      applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      checkAll("r.idle", 0, 0, 0);

      // One-shot count from 5 to terminal count
      applyStimulus(1'b1, 8'd5, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      checkAll("os.load", 5, 0, 0);
      applyStimulus(1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b0);
      tick();
      checkAll("os.start", 5, 1, 0);
      applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      for (int i = 4; i >= 1; i--) begin
         tick();
         checkAll("os.run", i, 1, 0);
      end
      tick();
      checkAll("os.term", 0, 0, 1);
      tick();
      checkAll("os.after", 0, 0, 0);

      // Auto-reload period of 3 (load+start out of DONE)
      applyStimulus(1'b1, 8'd3, 1'b1, 1'b0, 1'b1, 1'b1);
      tick();
      checkAll("ar.load", 3, 1, 0);
      applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 10; i++) begin
         tick();
         checkAll("ar.run", expSeq[i], 1, (i % 3 == 2) ? 1 : 0);
      end

      // Pause, resume, abort
      applyStimulus(1'b1, 8'd10, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      checkAll("pr.load", 10, 1, 0);
      applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      for (int i = 9; i >= 7; i--) begin
         tick();
         checkAll("pr.dec", i, 1, 0);
      end
      applyStimulus(1'b0, 8'd0, 1'b0, 1'b1, 1'b1, 1'b0);
      tick();
      checkAll("pr.pause", 7, 1, 0);
      applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         tick();
         checkAll("pr.hold", 7, 1, 0);
      end
      applyStimulus(1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b0);
      tick();
      checkAll("pr.resume", 7, 1, 0);
      applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      checkAll("pr.dec6", 6, 1, 0);
      applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      checkAll("pr.noen", 6, 1, 0);
      applyStimulus(1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      checkAll("pr.stop1", 6, 1, 0);
      tick();
      checkAll("pr.abort", 6, 0, 0);
      applyStimulus(1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      checkAll("pr.restart", 6, 1, 0);
      applyStimulus(1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      checkAll("pr.stop2", 6, 1, 0);
      applyStimulus(1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
      checkAll("pr.startstop", 6, 0, 0);

      // Load of zero with start, and load overriding a decrement
      applyStimulus(1'b1, 8'd0, 1'b1, 1'b0, 1'b1, 1'b0);
      tick();
      checkAll("lz.zero", 0, 0, 0);
      applyStimulus(1'b1, 8'd4, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      checkAll("lz.run4", 4, 1, 0);
      applyStimulus(1'b1, 8'd9, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      checkAll("lz.ovr", 9, 1, 0);
      applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      checkAll("lz.dec", 8, 1, 0);

`ifdef DOWN_TIMER_PRESCALE_EN
      // Prescaled count: 2 x 4 enabled cycles to terminal count
      applyStimulus(1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      repeat (2) tick();
      checkAll("ps.idle", 8, 0, 0);
      applyStimulus(1'b1, 8'd2, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b0);
      tick();
      checkAll("ps.start", 2, 1, 0);
      applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 8; i++) begin
         tick();
         if (i < 3)      checkAll("ps.two", 2, 1, 0);
         else if (i < 7) checkAll("ps.one", 1, 1, 0);
         else            checkAll("ps.term", 0, 0, 1);
      end
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
